// File: rtl/forthsuper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : forthsuper_pkg                                         |
// | Description : Shared types and constants for the forthsuper blocks:  |
// |               itoa FSM state encoding, ASCII constants and the        |
// |               nibble-to-character helper.                            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package forthsuper_pkg;

  typedef enum logic [2:0] {
    I0  = 3'd0,
    LDH = 3'd1,
    CNV = 3'd2,
    SGN = 3'd3,
    SKP = 3'd4,
    EMT = 3'd5,
    NUL = 3'd6,
    DON = 3'd7
  } itoa_sts;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_a     = 8'h61;
  localparam logic [7:0] CH_MINUS = 8'h2d;
  localparam logic [7:0] CH_NUL   = 8'h00;

  // 0-9 -> '0'..'9', 10-15 -> 'a'..'f'
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    if (d < 4'd10) return CH_0 + {4'd0, d};
    else           return CH_a + {4'd0, d} - 8'd10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/itoa_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : itoa_if                                                |
// | Description : Request/emission bundle of the itoa formatter.         |
// |               master: drives en/hex/vi, observes bsy/we/af/ch/st.    |
// |               slave : the formatter side.                            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface itoa_if
  import forthsuper_pkg::*;
#(
  parameter int DSZ = 32
);
  logic           en;
  logic           hex;
  logic [DSZ-1:0] vi;
  logic           bsy;
  logic           we;
  logic           af;
  logic [7:0]     ch;
  itoa_sts        st;

  modport master (output en, hex, vi, input bsy, we, af, ch, st);
  modport slave  (input en, hex, vi, output bsy, we, af, ch, st);
endinterface
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bin2bcd                                                |
// | Description : Sequential double-dabble converter with parallel load. |
// |   clk, rst : clock, asynchronous active-high reset                   |
// |   start    : load din as magnitude, run DSZ shift steps              |
// |   load     : load din nibbles directly into the digit buffer (hex)   |
// |   abort    : stop a running conversion                               |
// |   din      : DSZ-bit input value                                     |
// |   done     : high during the final shift step                        |
// |   bcd      : ND 4-bit digits, digit 0 least significant              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module bin2bcd #(
  parameter int DSZ = 32,
  parameter int ND  = 10
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic              load,
  input  wire logic              abort,
  input  wire logic [DSZ-1:0]    din,
  output logic                   done,
  output logic [4*ND-1:0]        bcd
);

  localparam int CW = $clog2(DSZ);

  logic [4*ND-1:0] bcd_q, bcd_d, adj;
  logic [DSZ-1:0]  mag_q, mag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;

  always_comb begin
    // add-3 correction on every digit that would overflow when doubled
    adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    bcd_d = bcd_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    run_d = run_q;

    if (abort) begin
      run_d = 1'b0;
    end else if (load) begin
      bcd_d          = '0;
      bcd_d[DSZ-1:0] = din;
      mag_d          = '0;
      run_d          = 1'b0;
    end else if (start) begin
      bcd_d = '0;
      mag_d = din;
      cnt_d = CW'(DSZ - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, mag_d} = {adj, mag_q} << 1;
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/itoa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : itoa                                                   |
// | Description : Integer-to-ASCII formatter. Writes signed decimal or   |
// |               unsigned lowercase hex text, MS digit first, then NUL. |
// |   clk, rst : clock, asynchronous active-high reset                   |
// |   bus.en   : start on high in idle, low aborts                       |
// |   bus.hex  : 0 signed decimal, 1 unsigned hex (sampled at start)     |
// |   bus.vi   : value to format (sampled at start)                      |
// |   bus.bsy  : conversion/emission in progress                         |
// |   bus.we   : memory write strobe for ch                              |
// |   bus.af   : address advance after the write                         |
// |   bus.ch   : character being written                                 |
// |   bus.st   : current state (debug)                                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module itoa
  import forthsuper_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int ND  = 10,
  parameter int ASZ = 17
) (
  input wire logic clk,
  input wire logic rst,
  itoa_if.slave    bus
);

  localparam int IW = (ND > 1) ? $clog2(ND) : 1;

  if (4*ND < DSZ || ASZ < 1) begin : g_param_chk
    $error("itoa: digit buffer too small for DSZ or bad ASZ");
  end

  itoa_sts         st_q, st_d;
  logic            bsy_q, bsy_d;
  logic            we_q, we_d;
  logic            af_q;
  logic [7:0]      ch_q, ch_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            neg_q, neg_d;

  logic            w_neg, w_start, w_load, w_done;
  logic [DSZ-1:0]  w_mag;
  logic [4*ND-1:0] w_bcd;
  logic [IW-1:0]   w_enc, w_prev;

  // Two's-complement negate wraps the most negative value onto its own
  // unsigned magnitude, which is exactly what we want to print.
  assign w_neg   = !bus.hex && bus.vi[DSZ-1];
  assign w_mag   = w_neg ? (-bus.vi) : bus.vi;
  assign w_start = (st_q == I0) && bus.en && !bus.hex;
  assign w_load  = (st_q == I0) && bus.en &&  bus.hex;
  assign w_prev  = idx_q - 1'b1;

  bin2bcd #(.DSZ(DSZ), .ND(ND)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .load  (w_load),
    .abort (!bus.en),
    .din   (w_mag),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // highest nonzero digit; all-zero yields 0 so a zero value prints "0"
  always_comb begin
    w_enc = '0;
    for (int i = 0; i < ND; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) w_enc = IW'(i);
    end
  end

  // Outputs are registered: the character for a state is set up on the
  // edge that enters that state, so we/ch line up with st.
  always_comb begin
    st_d  = st_q;
    bsy_d = bsy_q;
    we_d  = 1'b0;
    ch_d  = CH_NUL;
    idx_d = idx_q;
    neg_d = neg_q;

    if (!bus.en) begin
      st_d  = I0;
      bsy_d = 1'b0;
    end else begin
      case (st_q)
        I0: begin
          neg_d = w_neg;
          bsy_d = 1'b1;
          st_d  = bus.hex ? LDH : CNV;
        end
        LDH: st_d = SKP;
        CNV: begin
          if (w_done) begin
            if (neg_q) begin
              st_d = SGN;
              we_d = 1'b1;
              ch_d = CH_MINUS;
            end else begin
              st_d = SKP;
            end
          end
        end
        SGN: st_d = SKP;
        SKP: begin
          st_d  = EMT;
          idx_d = w_enc;
          we_d  = 1'b1;
          ch_d  = digit_ascii(w_bcd[{w_enc, 2'b00} +: 4]);
        end
        EMT: begin
          we_d = 1'b1;
          if (idx_q == '0) begin
            st_d = NUL;
            ch_d = CH_NUL;
          end else begin
            idx_d = w_prev;
            ch_d  = digit_ascii(w_bcd[{w_prev, 2'b00} +: 4]);
          end
        end
        NUL: begin
          st_d  = DON;
          bsy_d = 1'b0;
        end
        DON:     st_d = DON;
        default: st_d = I0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= I0;
      bsy_q <= 1'b0;
      we_q  <= 1'b0;
      af_q  <= 1'b0;
      ch_q  <= CH_NUL;
      idx_q <= '0;
      neg_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      bsy_q <= bsy_d;
      we_q  <= we_d;
      af_q  <= we_d;
      ch_q  <= ch_d;
      idx_q <= idx_d;
      neg_q <= neg_d;
    end
  end

  assign bus.st  = st_q;
  assign bus.bsy = bsy_q;
  assign bus.we  = we_q;
  assign bus.af  = af_q;
  assign bus.ch  = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_itoa.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_itoa                                                |
// | Description : Directed self-checking bench for the itoa formatter.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_itoa;
  import forthsuper_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itoa_if #(.DSZ(32)) bus ();

  itoa #(.DSZ(32), .ND(10), .ASZ(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  rule_viol = 0;
  byte wq[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_str(input string s);
    logic [127:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[119:0], s[i]};
    return v;
  endfunction

  // memory-side observer: record writes, watch af==we and ch==0 when idle
  always @(negedge clk) begin
    if (bus.we === 1'b1) wq.push_back(bus.ch);
    if (bus.af !== bus.we || (bus.we !== 1'b1 && bus.ch !== 8'h00)) rule_viol++;
  end

  task automatic run_conv(input string tag, input logic [31:0] v, input logic h,
                          input string exp, input int lat);
    int first = -1;
    int cyc   = 0;
    logic [127:0] got = '0;
    @(negedge clk);
    wq.delete();
    bus.vi  = v;
    bus.hex = h;
    bus.en  = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_bsy_start"}, bus.bsy, 1);
    while (bus.st != DON && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.we === 1'b1 && first < 0) first = cyc;
    end
    check({tag, "_reach_don"}, bus.st, DON);
    check({tag, "_latency"}, first, lat);
    check({tag, "_bsy_don"}, bus.bsy, 0);
    @(negedge clk);
    check({tag, "_nwrites"}, wq.size(), exp.len() + 1);
    if (wq.size() > 0) begin
      check({tag, "_nul"}, wq[wq.size()-1], 8'h00);
      for (int i = 0; i < wq.size() - 1; i++) got = {got[119:0], wq[i]};
    end
    check({tag, "_text"}, got, pack_str(exp));
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_idle"}, bus.st, I0);
  endtask

  initial begin
    int cyc;
    int n;
    logic [31:0] rv;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.hex = 1'b0;
    bus.vi  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_st",  bus.st,  I0);
    check("rst_bsy", bus.bsy, 0);
    check("rst_we",  bus.we,  0);
    check("rst_af",  bus.af,  0);
    check("rst_ch",  bus.ch,  8'h00);
    @(negedge clk);
    rst = 1'b0;

    run_conv("d1234",  32'd1234,     1'b0, "1234",        33);
    run_conv("dm56",   -32'sd56,     1'b0, "-56",         32);
    run_conv("dzero",  32'd0,        1'b0, "0",           33);
    run_conv("dmin",   32'h8000_0000, 1'b0, "-2147483648", 32);
    run_conv("dmax",   32'h7fff_ffff, 1'b0, "2147483647",  33);
    run_conv("dm1",    32'hffff_ffff, 1'b0, "-1",          32);
    run_conv("hdead",  32'hdead_beef, 1'b1, "deadbeef",    2);
    run_conv("hf",     32'h0000_000f, 1'b1, "f",           2);
    run_conv("hzero",  32'h0,        1'b1, "0",           2);
    run_conv("h1a0",   32'h0001_a00c, 1'b1, "1a00c",       2);

    for (int k = 0; k < 3; k++) begin
      rv = $urandom();
      run_conv("rnd_dec", rv, 1'b0, $sformatf("%0d", $signed(rv)), rv[31] ? 32 : 33);
      run_conv("rnd_hex", rv, 1'b1, $sformatf("%0h", rv), 2);
    end

    // abort mid-conversion, then a fresh conversion of a new value
    @(negedge clk);
    wq.delete();
    bus.vi  = 32'd1234;
    bus.hex = 1'b0;
    bus.en  = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_st",  bus.st,  I0);
    check("abort_bsy", bus.bsy, 0);
    check("abort_we",  bus.we,  0);
    @(negedge clk);
    check("abort_nwr", wq.size(), 0);
    run_conv("restart", 32'd7, 1'b0, "7", 33);

    // asynchronous reset during emission
    @(negedge clk);
    wq.delete();
    bus.vi  = 32'd987654321;
    bus.hex = 1'b0;
    bus.en  = 1'b1;
    cyc = 0;
    while (bus.st != EMT && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("arst_reach_emt", bus.st, EMT);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we",  bus.we,  0);
    check("arst_af",  bus.af,  0);
    check("arst_bsy", bus.bsy, 0);
    check("arst_st",  bus.st,  I0);
    n = wq.size();
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_nwr",  wq.size(), n);
    check("arst_idle", bus.st, I0);

    check("af_we_ch_rule", rule_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
